// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// The CPU/loader grant encoding matches the bit positions of the request vector.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_LD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: req[0] is the CPU, req[1] the loader.
// When both requesters are active, the one that was not served last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  assign any    = |req;
  // Loader wins when it is alone, or on a tie when the CPU was served last.
  assign winner = req[1] & (~req[0] | (last == GRANT_CPU));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU controller and the program loader,
// one access per grant, round-robin on contention.
//
// state    | meaning
// ST_IDLE  | wait for a request; pick a winner and capture its access
// ST_ISSUE | drive the captured access to memory (mem_en high)
// ST_DONE  | ack the winner, return read data, record last-served
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic pick_winner;
  logic pick_any;

  rr_pick2 u_pick (
    .req    ({ld_req, cpu_req}),
    .last   (last_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_ISSUE;
          grant_d = pick_winner;
          if (pick_winner == GRANT_LD) begin
            we_d    = ld_we;
            addr_d  = ld_addr;
            wdata_d = ld_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ST_ISSUE: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = grant_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Last-served starts at the loader so the CPU takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_CPU;
      last_q  <= GRANT_LD;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobes and acks decode straight from state so a reset in DONE still shows the ack.
  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == ST_DONE) && (grant_q == GRANT_CPU);
  assign ld_ack    = (state_q == ST_DONE) && (grant_q == GRANT_LD);
  assign rdata     = ((state_q == ST_DONE) && !we_q) ? mem_rdata : '0;
  assign busy      = (state_q != ST_IDLE);
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_req, cpu_we, ld_req, ld_we;
  logic [4:0] cpu_addr, ld_addr;
  logic [7:0] cpu_wdata, ld_wdata;
  logic       cpu_ack, ld_ack;
  logic [7:0] rdata;
  logic       mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy, grant;

  logic [7:0] mem [32];
  logic       bd_we;
  logic [4:0] bd_addr;
  logic [7:0] bd_data;

  int total;
  int bad;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro model: write commits at the edge ending the strobe cycle,
  // read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0; ld_wdata  = '0;
    bd_we = 1'b1; bd_addr = 5'd3; bd_data = 8'hA5;
    step();
    bd_addr = 5'd2; bd_data = 8'h5A;
    step();
    bd_addr = 5'd9; bd_data = 8'h99;
    step();
    bd_we = 1'b0;
    rst = 1'b1;

    // reset state
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_ld_ack", 32'(ld_ack), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);

    // single CPU read of addr 3
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
    step();
    chk("rd_c1_mem_en", 32'(mem_en), 1);
    chk("rd_c1_mem_we", 32'(mem_we), 0);
    chk("rd_c1_mem_addr", 32'(mem_addr), 3);
    chk("rd_c1_busy", 32'(busy), 1);
    chk("rd_c1_cpu_ack", 32'(cpu_ack), 0);
    step();
    chk("rd_c2_cpu_ack", 32'(cpu_ack), 1);
    chk("rd_c2_ld_ack", 32'(ld_ack), 0);
    chk("rd_c2_rdata", 32'(rdata), 'hA5);
    chk("rd_c2_mem_en", 32'(mem_en), 0);
    cpu_req = 1'b0;
    step();
    chk("rd_c3_busy", 32'(busy), 0);
    chk("rd_c3_cpu_ack", 32'(cpu_ack), 0);
    chk("rd_c3_rdata", 32'(rdata), 0);

    // loader write 3C to addr 7, then CPU read of addr 7
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 5'd7; ld_wdata = 8'h3C;
    step();
    chk("lw_grant", 32'(grant), 1);
    chk("lw_mem_en", 32'(mem_en), 1);
    chk("lw_mem_we", 32'(mem_we), 1);
    chk("lw_mem_addr", 32'(mem_addr), 7);
    chk("lw_mem_wdata", 32'(mem_wdata), 'h3C);
    step();
    chk("lw_ld_ack", 32'(ld_ack), 1);
    chk("lw_cpu_ack", 32'(cpu_ack), 0);
    chk("lw_rdata", 32'(rdata), 0);
    ld_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd7;
    step();
    chk("lw_idle_busy", 32'(busy), 0);
    step();
    chk("cr_grant", 32'(grant), 0);
    chk("cr_mem_addr", 32'(mem_addr), 7);
    step();
    chk("cr_cpu_ack", 32'(cpu_ack), 1);
    chk("cr_rdata", 32'(rdata), 'h3C);
    cpu_req = 1'b0;
    step();

    // contention from reset: CPU, LD, CPU, LD, three cycles apart
    rst = 1'b0;
    step();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 5'd7;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("rr_cpu_ack_c%0d", k), 32'(cpu_ack), 32'((k == 2) || (k == 8)));
      chk($sformatf("rr_ld_ack_c%0d", k), 32'(ld_ack), 32'((k == 5) || (k == 11)));
      chk($sformatf("rr_mem_en_c%0d", k), 32'(mem_en), 32'((k % 3) == 1));
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    step();
    chk("rr_end_busy", 32'(busy), 0);

    // captured address immune to input change during ISSUE
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd2;
    step();
    chk("cap_issue_addr", 32'(mem_addr), 2);
    cpu_addr = 5'd9;
    step();
    chk("cap_done_addr", 32'(mem_addr), 2);
    chk("cap_done_ack", 32'(cpu_ack), 1);
    chk("cap_done_rdata", 32'(rdata), 'h5A);
    cpu_req = 1'b0;
    step();

    // reset during a loader write in ISSUE
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 5'd4; ld_wdata = 8'h11;
    step();
    chk("rsti_mem_en", 32'(mem_en), 1);
    chk("rsti_mem_we", 32'(mem_we), 1);
    rst = 1'b0;
    ld_req = 1'b0;
    step();
    rst = 1'b1;
    chk("rsti_ld_ack", 32'(ld_ack), 0);
    chk("rsti_cpu_ack", 32'(cpu_ack), 0);
    chk("rsti_busy", 32'(busy), 0);
    chk("rsti_mem_en", 32'(mem_en), 0);
    chk("rsti_mem_we", 32'(mem_we), 0);
    chk("rsti_mem_addr", 32'(mem_addr), 0);
    chk("rsti_mem_wdata", 32'(mem_wdata), 0);
    chk("rsti_rdata", 32'(rdata), 0);
    chk("rsti_grant", 32'(grant), 0);
    chk("rsti_mem4", 32'(mem[4]), 'h11);
    step();
    chk("rsti_next_ld_ack", 32'(ld_ack), 0);

    // idle stability
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("idle_mem_en_%0d", k), 32'(mem_en), 0);
      chk($sformatf("idle_cpu_ack_%0d", k), 32'(cpu_ack), 0);
      chk($sformatf("idle_ld_ack_%0d", k), 32'(ld_ack), 0);
      chk($sformatf("idle_busy_%0d", k), 32'(busy), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Acks must never coincide.
  always @(negedge clk) begin
    if (rst) begin
      assert (!(cpu_ack && ld_ack)) else begin
        bad++;
        $error("FAIL both_acks observed=11 expected=not both");
      end
    end
  end

endmodule
